// File: rtl/avalon_mm_pkg.sv
// Shared types and width helpers for the pipelined Avalon-MM bridge and its testbench.
package avalon_mm_pkg;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int cnt_width(input int max_pending);
      return $clog2(max_pending + 1);
   endfunction

   localparam int AVMM_DATA_W = 32;
   localparam int AVMM_ADDR_W = 32;
   localparam int AVMM_BE_W   = be_width(AVMM_DATA_W);

   typedef struct packed {
      logic [AVMM_ADDR_W-1:0] addr;
      logic                   rd;
      logic                   wr;
      logic [AVMM_DATA_W-1:0] wdata;
      logic [AVMM_BE_W-1:0]   be;
   } avalon_mm_cmd_t;

endpackage

// File: rtl/avalon_mm_cmd_slice.sv
// Single-entry Avalon-MM command register: loads on accept, drops its request
// strobes once the downstream slave takes the command.
module avalon_mm_cmd_slice
   import avalon_mm_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  drain,
   input  logic [ADDR_WIDTH-1:0] ld_address,
   input  logic                  ld_read,
   input  logic                  ld_write,
   input  logic [DATA_WIDTH-1:0] ld_writedata,
   input  logic [BE_WIDTH-1:0]   ld_byteenable,
   output logic                  cmd_vld,
   output logic [ADDR_WIDTH-1:0] m_address,
   output logic                  m_read,
   output logic                  m_write,
   output logic [DATA_WIDTH-1:0] m_writedata,
   output logic [BE_WIDTH-1:0]   m_byteenable
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  rd;
      logic                  wr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
   } slot_t;

   slot_t slot_d, slot_q;
   logic  cmd_vld_d, cmd_vld_q;

   always_comb begin
      slot_d    = slot_q;
      cmd_vld_d = cmd_vld_q;
      if (load) begin
         slot_d.addr  = ld_address;
         slot_d.rd    = ld_read;
         slot_d.wr    = ld_write;
         slot_d.wdata = ld_writedata;
         slot_d.be    = ld_byteenable;
         cmd_vld_d    = 1'b1;
      end else if (drain) begin
         // Payload stays put; only the strobes drop so m_* remains purely registered.
         slot_d.rd = 1'b0;
         slot_d.wr = 1'b0;
         cmd_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q    <= '0;
         cmd_vld_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         cmd_vld_q <= cmd_vld_d;
      end
   end

   assign cmd_vld      = cmd_vld_q;
   assign m_address    = slot_q.addr;
   assign m_read       = slot_q.rd;
   assign m_write      = slot_q.wr;
   assign m_writedata  = slot_q.wdata;
   assign m_byteenable = slot_q.be;

endmodule

// File: rtl/avalon_mm_pipeline_bridge.sv
// Pipelined Avalon-MM bridge: registered command slot, registered read return,
// outstanding-read limiter and a sticky protocol-violation flag.
module avalon_mm_pipeline_bridge
   import avalon_mm_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MAX_PENDING = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [ADDR_WIDTH-1:0]               s_address,
   input  logic                                s_read,
   input  logic                                s_write,
   input  logic [DATA_WIDTH-1:0]               s_writedata,
   input  logic [be_width(DATA_WIDTH)-1:0]     s_byteenable,
   output logic                                s_waitrequest,
   output logic [DATA_WIDTH-1:0]               s_readdata,
   output logic                                s_readdatavalid,
   output logic [ADDR_WIDTH-1:0]               m_address,
   output logic                                m_read,
   output logic                                m_write,
   output logic [DATA_WIDTH-1:0]               m_writedata,
   output logic [be_width(DATA_WIDTH)-1:0]     m_byteenable,
   input  logic                                m_waitrequest,
   input  logic [DATA_WIDTH-1:0]               m_readdata,
   input  logic                                m_readdatavalid,
   output logic [cnt_width(MAX_PENDING)-1:0]   pending_cnt,
   output logic                                protocol_err
);

   localparam int                BE_W    = be_width(DATA_WIDTH);
   localparam int                CNT_W   = cnt_width(MAX_PENDING);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_PENDING);

   logic                  ready_d, ready_q;
   logic [CNT_W-1:0]      pending_cnt_d, pending_cnt_q;
   logic                  s_readdatavalid_d, s_readdatavalid_q;
   logic [DATA_WIDTH-1:0] s_readdata_d, s_readdata_q;
   logic                  protocol_err_d, protocol_err_q;

   logic cmd_vld;
   logic drain;
   logic slot_free;
   logic rd_block;
   logic accept;
   logic dual_req;
   logic rd_accept;
   logic spurious_rsp;

   assign drain         = cmd_vld & ~m_waitrequest;
   assign slot_free     = ~cmd_vld | drain;
   assign rd_block      = s_read & (pending_cnt_q == CNT_MAX);
   assign s_waitrequest = ~ready_q | ~slot_free | rd_block;
   assign accept        = (s_read | s_write) & ~s_waitrequest;
   assign dual_req      = s_read & s_write;
   assign rd_accept     = accept & s_read & ~s_write;

   // A response is unexpected when every counted read has already come back on m_*.
   assign spurious_rsp  = m_readdatavalid & ~rd_accept &
                          (pending_cnt_q <= CNT_W'(s_readdatavalid_q));

   avalon_mm_cmd_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BE_WIDTH   (BE_W)
   ) u_cmd_slice (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (accept),
      .drain         (drain),
      .ld_address    (s_address),
      .ld_read       (s_read & ~s_write),
      .ld_write      (s_write),
      .ld_writedata  (s_writedata),
      .ld_byteenable (s_byteenable),
      .cmd_vld       (cmd_vld),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable)
   );

   always_comb begin
      ready_d           = 1'b1;
      s_readdatavalid_d = m_readdatavalid;
      s_readdata_d      = m_readdatavalid ? m_readdata : s_readdata_q;
      protocol_err_d    = protocol_err_q | (accept & dual_req) | spurious_rsp;
      pending_cnt_d     = pending_cnt_q;
      if (rd_accept && !s_readdatavalid_q) begin
         pending_cnt_d = pending_cnt_q + 1'b1;
      end else if (!rd_accept && s_readdatavalid_q && (pending_cnt_q != '0)) begin
         pending_cnt_d = pending_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q           <= 1'b0;
         pending_cnt_q     <= '0;
         s_readdatavalid_q <= 1'b0;
         s_readdata_q      <= '0;
         protocol_err_q    <= 1'b0;
      end else begin
         ready_q           <= ready_d;
         pending_cnt_q     <= pending_cnt_d;
         s_readdatavalid_q <= s_readdatavalid_d;
         s_readdata_q      <= s_readdata_d;
         protocol_err_q    <= protocol_err_d;
      end
   end

   assign s_readdata      = s_readdata_q;
   assign s_readdatavalid = s_readdatavalid_q;
   assign pending_cnt     = pending_cnt_q;
   assign protocol_err    = protocol_err_q;

endmodule

// File: tb/tb_avalon_mm_pipeline_bridge.sv
// Scoreboard testbench for avalon_mm_pipeline_bridge: directed upstream commands,
// a 3-clock-latency downstream slave model and a monitor checking both directions.
module tb_avalon_mm_pipeline_bridge;
   import avalon_mm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_address;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest;
   logic [31:0] m_readdata = '0;
   logic        m_readdatavalid = 1'b0;
   logic [2:0]  pending_cnt;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;
   int stalls;
   int stalls_b;
   int spur_cnt = 0;
   logic [31:0] spur_data = '0;

   avalon_mm_cmd_t exp_cmd_q[$];
   logic [31:0]    exp_rsp_q[$];

   typedef struct {
      int          due;
      logic [31:0] data;
   } slv_rsp_t;

   avalon_mm_pipeline_bridge #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .MAX_PENDING (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .pending_cnt     (pending_cnt),
      .protocol_err    (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Holds one upstream command until accepted (bounded), queueing what must appear downstream.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_data, output int n_stall);
      avalon_mm_cmd_t c;
      int n = 0;
      s_read       = rd;
      s_write      = wr;
      s_address    = addr;
      s_writedata  = wdata;
      s_byteenable = be;
      #1;
      while (s_waitrequest && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got stall of %0d clks at addr 0x%0h, expected acceptance", n, addr);
      end else begin
         c.addr  = addr;
         c.rd    = rd & ~wr;
         c.wr    = wr;
         c.wdata = wdata;
         c.be    = be;
         exp_cmd_q.push_back(c);
         if (rd && !wr) exp_rsp_q.push_back(exp_data);
      end
      @(negedge clk);
      s_read  = 1'b0;
      s_write = 1'b0;
      n_stall = n;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((pending_cnt != 3'd0 || exp_rsp_q.size() != 0 || exp_cmd_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_pending_cnt", {29'd0, pending_cnt}, 32'd0);
      checkOutput("idle_rsp_queue", exp_rsp_q.size(), 32'd0);
   endtask

   // Downstream slave: returns {addr[15:0],16'hCAFE} three clocks after taking a read.
   task automatic run_slave();
      slv_rsp_t slv_q[$];
      slv_rsp_t r;
      int cycle = 0;
      int spur_done = 0;
      forever begin
         @(negedge clk);
         #1;
         cycle++;
         m_readdatavalid = 1'b0;
         if (!rst_n) begin
            slv_q.delete();
            spur_done = spur_cnt;
         end else begin
            if (spur_done != spur_cnt) begin
               m_readdatavalid = 1'b1;
               m_readdata      = spur_data;
               spur_done++;
            end else if (slv_q.size() != 0 && slv_q[0].due == cycle) begin
               r               = slv_q.pop_front();
               m_readdatavalid = 1'b1;
               m_readdata      = r.data;
            end
            if (m_read && !m_waitrequest) begin
               r.due  = cycle + 3;
               r.data = {m_address[15:0], 16'hCAFE};
               slv_q.push_back(r);
            end
         end
      end
   endtask

   // Monitor: compares every presented downstream command and every upstream response.
   task automatic run_monitor();
      logic        prev_mrdv  = 1'b0;
      logic [31:0] last_sdata = '0;
      logic [31:0] exp_d;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_mrdv  = 1'b0;
            last_sdata = '0;
            continue;
         end
         if (m_read || m_write) begin
            if (exp_cmd_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_cmd: got addr 0x%0h rd %0b wr %0b, expected no command",
                        m_address, m_read, m_write);
            end else begin
               checkOutput("m_address", m_address, exp_cmd_q[0].addr);
               checkOutput("m_read", m_read, exp_cmd_q[0].rd);
               checkOutput("m_write", m_write, exp_cmd_q[0].wr);
               checkOutput("m_writedata", m_writedata, exp_cmd_q[0].wdata);
               checkOutput("m_byteenable", m_byteenable, exp_cmd_q[0].be);
               if (!m_waitrequest) void'(exp_cmd_q.pop_front());
            end
         end
         if (s_readdatavalid || prev_mrdv) checkOutput("s_readdatavalid_latency", s_readdatavalid, prev_mrdv);
         if (s_readdatavalid) begin
            if (exp_rsp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp: got data 0x%0h, expected no response", s_readdata);
            end else begin
               exp_d = exp_rsp_q.pop_front();
               checkOutput("s_readdata", s_readdata, exp_d);
               last_sdata = exp_d;
            end
         end else begin
            checkOutput("s_readdata_hold", s_readdata, last_sdata);
         end
         prev_mrdv = m_readdatavalid;
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      s_read        = 1'b0;
      s_write       = 1'b0;
      s_address     = '0;
      s_writedata   = '0;
      s_byteenable  = '0;
      m_waitrequest = 1'b0;
      fork
         run_monitor();
         run_slave();
         begin
            #50000;
            errors++;
            $display("[TB] FAIL watchdog: got no completion, expected finish before 50000 time units");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      join_none

      // Reset state
      #3;
      checkOutput("rst_s_waitrequest", s_waitrequest, 32'd1);
      checkOutput("rst_m_read", m_read, 32'd0);
      checkOutput("rst_m_write", m_write, 32'd0);
      checkOutput("rst_pending_cnt", {29'd0, pending_cnt}, 32'd0);
      checkOutput("rst_protocol_err", protocol_err, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("first_cycle_s_waitrequest", s_waitrequest, 32'd1);

      // 1: single write, one stall for the ready flop, then m_write one clock later
      $display("[TB] test 1: single write");
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, stalls);
      checkOutput("t1_stalls", stalls, 32'd1);
      #1;
      checkOutput("t1_m_write", m_write, 32'd1);
      checkOutput("t1_m_address", m_address, 32'h10);
      checkOutput("t1_m_writedata", m_writedata, 32'hDEADBEEF);

      // 2: four back-to-back reads
      $display("[TB] test 2: four pipelined reads");
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0100CAFE, stalls);
      checkOutput("t2_stalls_0", stalls, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 32'h0104CAFE, stalls);
      checkOutput("t2_stalls_1", stalls, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h108, 32'h0, 4'hF, 32'h0108CAFE, stalls);
      checkOutput("t2_stalls_2", stalls, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h10C, 32'h0, 4'hF, 32'h010CCAFE, stalls);
      checkOutput("t2_stalls_3", stalls, 32'd0);
      #1;
      checkOutput("t2_pending_peak", {29'd0, pending_cnt}, 32'd4);

      // 3: fifth read waits for the first response to leave the bridge
      $display("[TB] test 3: read blocked at MAX_PENDING");
      applyStimulus(1'b1, 1'b0, 32'h110, 32'h0, 4'hF, 32'h0110CAFE, stalls);
      checkOutput("t3_stalls", stalls, 32'd2);
      wait_idle();
      checkOutput("t3_protocol_err", protocol_err, 32'd0);

      // 4: downstream stall holds write A for six clocks, write B accepted on the drain clock
      $display("[TB] test 4: downstream backpressure");
      m_waitrequest = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'h5, 32'h0, stalls);
      checkOutput("t4_stalls_a", stalls, 32'd0);
      fork
         applyStimulus(1'b0, 1'b1, 32'h24, 32'h0F0F0F0F, 4'hC, 32'h0, stalls_b);
         begin
            repeat (6) @(negedge clk);
            m_waitrequest = 1'b0;
         end
      join
      checkOutput("t4_stalls_b", stalls_b, 32'd6);
      wait_idle();

      // 5: simultaneous read and write, then a spurious response
      $display("[TB] test 5: protocol violations");
      applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 32'h0, stalls);
      #1;
      checkOutput("t5_m_write", m_write, 32'd1);
      checkOutput("t5_m_read", m_read, 32'd0);
      checkOutput("t5_protocol_err", protocol_err, 32'd1);
      checkOutput("t5_pending_cnt", {29'd0, pending_cnt}, 32'd0);
      @(negedge clk);
      spur_data = 32'hBAD00001;
      spur_cnt++;
      exp_rsp_q.push_back(32'hBAD00001);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("t5_spur_pending_cnt", {29'd0, pending_cnt}, 32'd0);
      checkOutput("t5_spur_protocol_err", protocol_err, 32'd1);
      wait_idle();

      // 6: reset with two reads outstanding and a held command
      $display("[TB] test 6: reset mid-transaction");
      applyStimulus(1'b1, 1'b0, 32'h180, 32'h0, 4'hF, 32'h0180CAFE, stalls);
      applyStimulus(1'b1, 1'b0, 32'h184, 32'h0, 4'hF, 32'h0184CAFE, stalls);
      m_waitrequest = 1'b1;
      #1;
      checkOutput("t6_pending_before", {29'd0, pending_cnt}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_s_waitrequest", s_waitrequest, 32'd1);
      checkOutput("t6_rst_m_read", m_read, 32'd0);
      checkOutput("t6_rst_m_address", m_address, 32'd0);
      checkOutput("t6_rst_pending_cnt", {29'd0, pending_cnt}, 32'd0);
      checkOutput("t6_rst_protocol_err", protocol_err, 32'd0);
      checkOutput("t6_rst_s_readdata", s_readdata, 32'd0);
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      repeat (2) @(negedge clk);
      m_waitrequest = 1'b0;
      rst_n = 1'b1;
      #1;
      checkOutput("t6_rel_pending_cnt", {29'd0, pending_cnt}, 32'd0);
      checkOutput("t6_rel_protocol_err", protocol_err, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'h0200CAFE, stalls);
      checkOutput("t6_post_stalls", stalls, 32'd1);
      wait_idle();
      checkOutput("end_cmd_queue", exp_cmd_q.size(), 32'd0);
      checkOutput("end_protocol_err", protocol_err, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
